mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage of the pipelined RISC Toy core; sits directly upstream of the MEM/WB pipeline register.
- Holds the EX/MEM pipeline entry and performs the load/store on a ready-handshaked data-memory port.
- Selects the write-back value: load data, PC+4 or ALU result.
- Drives the MEM/WB inputs, including the bubble (Stall), and freezes upstream stages while memory is busy.

Parameters:
- MAX_WAIT, 16: consecutive unanswered request cycles before an access is aborted (legal range 2..255).
- WAIT_W, 8: width of the wait counter.

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX stage presents a real instruction
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_sel_pc4  in  1  write back PC+4 (jump-and-link)
- ex_wb_control  in  2  [1]=RegWrite, [0]=passed through to WB
- ex_alu_result  in  32  ALU result / memory address
- ex_pc_plus_4  in  32  link value
- ex_store_data  in  32  store data
- ex_rd  in  5  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  address
- dmem_wdata  out  32  write data
- dmem_ready  in  1  access completes this cycle
- dmem_rdata  in  32  load data, valid when dmem_ready=1
- stall_upstream  out  1  freeze PC and IF/ID/EX registers
- WB_control  out  2  to MEM_WB
- wb_value  out  32  to MEM_WB ALUresult_or_PC_plus_4
- rd  out  5  to MEM_WB
- Stall  out  1  to MEM_WB; 1 = insert bubble
- fwd_valid  out  1  forwarding value valid this cycle
- fwd_value  out  32  forwarding value (equals wb_value)
- bus_err  out  1  sticky access-timeout flag

Behaviour:
- Entry register fields: valid, mem_read, mem_write, sel_pc4, wb_control, alu_result, pc_plus_4, store_data, rd.
  - Loads all ex_* inputs on every rising edge where stall_upstream=0.
  - Holds while stall_upstream=1; ex_* inputs are ignored.
- FSM states: IDLE, ACCESS.
  - On an edge where the entry loads with ex_valid & (ex_mem_read|ex_mem_write): next state ACCESS, wait counter cleared. Otherwise next state IDLE.
  - ACCESS: dmem_req=1, dmem_we=mem_write, dmem_addr=alu_result, dmem_wdata=store_data.
  - ACCESS done condition: dmem_ready=1, or timeout (wait counter = MAX_WAIT-1 with dmem_ready=0).
  - ACCESS, done: retire this cycle; next state is decided by the newly loaded entry.
  - ACCESS, not done: counter +1, stall_upstream=1.
  - IDLE: dmem_req=0; all dmem_* outputs are 0.
- Single-cycle memory (ready in the first ACCESS cycle) gives zero stall cycles; each wait cycle adds exactly one stall cycle.
- Retire (combinational, this cycle) = valid & (state IDLE, or ACCESS & done).
- MEM/WB outputs:
  - Stall = ~retire.
  - WB_control = wb_control.
  - rd = rd.
  - wb_value selection: mem_read ? (timeout ? 0 : dmem_rdata) : sel_pc4 ? pc_plus_4 : alu_result.
  - MEM_WB zeroes WB_control itself when Stall=1.
- stall_upstream = valid & state ACCESS & ~done.
- Forwarding: fwd_valid = retire & wb_control[1]; a load forwards only in its completing cycle.
- Timeout: store is dropped; load returns 0. bus_err is set at the edge and held until reset.
- Entry with ex_valid=0 never requests memory; Stall=1 while it is held.
- Reset (async, any time, including mid-access): entry valid=0, state IDLE, counter 0, bus_err=0.
  - Immediately after reset: dmem_req=0, stall_upstream=0, Stall=1, WB_control=0, wb_value=0, rd=0, fwd_valid=0.
- All arithmetic is unsigned; the counter never wraps because it is cleared on every ACCESS entry.

Decomposition:
- Shared package: WB_RW_BIT=1, state encoding (IDLE=0, ACCESS=1), DATA_W=32, REG_W=5.
- One natural sub-module: mem_wait_timer (counter plus timeout compare, clear/increment inputs, timeout output).
- Entry register and FSM stay in the top.

Test Plan:
1. ALU op, alu_result=0x0000_0010, rd=3, WB=2'b10 → next cycle Stall=0, wb_value=0x10, fwd_valid=1, dmem_req=0.
2. Load addr 0x100, ready on first ACCESS cycle, rdata=0xDEAD_BEEF → no stall; wb_value=0xDEADBEEF, rd forwarded in that cycle.
3. Store 0x200/0x1234, ready after 3 wait cycles → stall_upstream=1 for 3 cycles, Stall=1 for 3 cycles, dmem_we=1, upstream entry unchanged, then retire.
4. JAL with pc_plus_4=0x44 → wb_value=0x44 regardless of alu_result.
5. Load, ready never asserted, MAX_WAIT=16 → 15 stall cycles, retire on 16th with wb_value=0, bus_err=1 sticky.
6. RSTN low in the 2nd wait cycle of a load → dmem_req=0 and Stall=1 immediately. After release, a new load issues cleanly and bus_err=0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access stage of the RISC Toy core.
// Also holds the entry record layout and the write-back value selector.
package mem_access_stage_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_W     = 5;
    localparam int WB_RW_BIT = 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              mem_write;
        logic              sel_pc4;
        logic [1:0]        wb_control;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] pc_plus_4;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rd;
    } entry_t;

    // A timed-out load returns zero instead of whatever is on the read bus.
    function automatic logic [DATA_W-1:0] sel_wb_value(
        input entry_t            e,
        input logic              timed_out,
        input logic [DATA_W-1:0] rdata
    );
        logic [DATA_W-1:0] v;
        if (e.mem_read) begin
            v = timed_out ? {DATA_W{1'b0}} : rdata;
        end else if (e.sel_pc4) begin
            v = e.pc_plus_4;
        end else begin
            v = e.alu_result;
        end
        return v;
    endfunction

endpackage

// File: rtl/mem_access_stage_wait_timer.sv
// Wait-cycle counter for an outstanding data-memory access.
// Flags timeout once MAX_WAIT-1 unanswered cycles have been counted.
module mem_wait_timer
    import mem_access_stage_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 8
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic clear_i,
    input  logic inc_i,
    output logic timeout_o
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Clear has priority; the counter never wraps since every access starts from zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {WAIT_W{1'b0}};
        end else if (inc_i) begin
            count_d = count_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count_q <= {WAIT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = (count_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: holds the EX/MEM entry, runs the load/store handshake and
// produces the MEM/WB inputs plus the upstream freeze.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_sel_pc4,
    input  logic [1:0]        ex_wb_control,
    input  logic [31:0]       ex_alu_result,
    input  logic [31:0]       ex_pc_plus_4,
    input  logic [31:0]       ex_store_data,
    input  logic [4:0]        ex_rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [31:0]       dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_upstream,
    output logic [1:0]        WB_control,
    output logic [31:0]       wb_value,
    output logic [4:0]        rd,
    output logic              Stall,
    output logic              fwd_valid,
    output logic [31:0]       fwd_value,
    output logic              bus_err
);

    entry_t     entry_q;
    entry_t     entry_d;
    mem_state_e state_q;
    mem_state_e state_d;
    logic       bus_err_q;
    logic       bus_err_d;

    logic       wait_to_s;
    logic       in_access_s;
    logic       done_s;
    logic       timeout_s;
    logic       retire_s;
    logic       stall_s;
    logic       start_acc_s;
    logic [31:0] wb_value_s;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_timer (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .clear_i   (~stall_s),
        .inc_i     (stall_s),
        .timeout_o (wait_to_s)
    );

    // Access status: completion, timeout, retire and freeze.
    always_comb begin
        in_access_s = (state_q == ST_ACCESS);
        done_s      = dmem_ready | wait_to_s;
        timeout_s   = in_access_s & wait_to_s & ~dmem_ready;
        retire_s    = entry_q.valid & (~in_access_s | done_s);
        stall_s     = entry_q.valid & in_access_s & ~done_s;
        start_acc_s = ex_valid & (ex_mem_read | ex_mem_write);
    end

    // Next entry, next state and sticky error; a frozen stage ignores ex_* inputs.
    always_comb begin
        entry_d   = entry_q;
        state_d   = state_q;
        bus_err_d = bus_err_q | timeout_s;
        if (!stall_s) begin
            entry_d.valid      = ex_valid;
            entry_d.mem_read   = ex_mem_read;
            entry_d.mem_write  = ex_mem_write;
            entry_d.sel_pc4    = ex_sel_pc4;
            entry_d.wb_control = ex_wb_control;
            entry_d.alu_result = ex_alu_result;
            entry_d.pc_plus_4  = ex_pc_plus_4;
            entry_d.store_data = ex_store_data;
            entry_d.rd         = ex_rd;
            state_d            = start_acc_s ? ST_ACCESS : ST_IDLE;
        end else begin
            entry_d = entry_q;
            state_d = state_q;
        end
    end

    // Entry, FSM state and error flag registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            entry_q   <= '0;
            state_q   <= ST_IDLE;
            bus_err_q <= 1'b0;
        end else begin
            entry_q   <= entry_d;
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Memory port is only driven while an access is outstanding.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0000_0000;
        dmem_wdata = 32'h0000_0000;
        case (state_q)
            ST_ACCESS: begin
                dmem_req   = 1'b1;
                dmem_we    = entry_q.mem_write;
                dmem_addr  = entry_q.alu_result;
                dmem_wdata = entry_q.store_data;
            end
            default: begin
                dmem_req   = 1'b0;
                dmem_we    = 1'b0;
                dmem_addr  = 32'h0000_0000;
                dmem_wdata = 32'h0000_0000;
            end
        endcase
    end

    assign wb_value_s     = sel_wb_value(entry_q, timeout_s, dmem_rdata);
    assign stall_upstream = stall_s;
    assign Stall          = ~retire_s;
    assign WB_control     = entry_q.wb_control;
    assign rd             = entry_q.rd;
    assign wb_value       = wb_value_s;
    assign fwd_valid      = retire_s & entry_q.wb_control[WB_RW_BIT];
    assign fwd_value      = wb_value_s;
    assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU/load/store/JAL retire, wait stalls,
// access timeout with sticky bus_err, and asynchronous reset mid-access.
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_sel_pc4;
    logic [1:0]  ex_wb_control;
    logic [31:0] ex_alu_result, ex_pc_plus_4, ex_store_data;
    logic [4:0]  ex_rd;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall_upstream, Stall, fwd_valid, bus_err;
    logic [1:0]  WB_control;
    logic [31:0] wb_value, fwd_value;
    logic [4:0]  rd;

    int checks   = 0;
    int failures = 0;

    mem_access_stage #(.MAX_WAIT(16), .WAIT_W(8)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_sel_pc4(ex_sel_pc4), .ex_wb_control(ex_wb_control),
        .ex_alu_result(ex_alu_result), .ex_pc_plus_4(ex_pc_plus_4),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall_upstream(stall_upstream), .WB_control(WB_control), .wb_value(wb_value),
        .rd(rd), .Stall(Stall), .fwd_valid(fwd_valid), .fwd_value(fwd_value),
        .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic r, input logic w, input logic p4,
                          input logic [1:0] wb, input logic [31:0] alu,
                          input logic [31:0] pc, input logic [31:0] sd, input logic [4:0] d);
        ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_sel_pc4 = p4;
        ex_wb_control = wb; ex_alu_result = alu; ex_pc_plus_4 = pc;
        ex_store_data = sd; ex_rd = d;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RSTN = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        #12;
        check("rst_req",    {31'd0, dmem_req},       32'd0);
        check("rst_stup",   {31'd0, stall_upstream}, 32'd0);
        check("rst_Stall",  {31'd0, Stall},          32'd1);
        check("rst_wbc",    {30'd0, WB_control},     32'd0);
        check("rst_wbv",    wb_value,                32'd0);
        check("rst_rd",     {27'd0, rd},             32'd0);
        check("rst_fwd",    {31'd0, fwd_valid},      32'd0);
        check("rst_berr",   {31'd0, bus_err},        32'd0);
        RSTN = 1'b1;

        // 1: ALU op
        set_ex(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0, 32'h0, 5'd3);
        tick();
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0, 32'h0, 5'd5);
        #1;
        check("alu_Stall", {31'd0, Stall},     32'd0);
        check("alu_wbv",   wb_value,           32'h10);
        check("alu_fwd",   {31'd0, fwd_valid}, 32'd1);
        check("alu_req",   {31'd0, dmem_req},  32'd0);
        check("alu_rd",    {27'd0, rd},        32'd3);
        check("alu_wbc",   {30'd0, WB_control}, 32'd2);

        // 2: load, single-cycle memory; store presented behind it
        tick();
        set_ex(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0200, 32'h0, 32'h0000_1234, 5'd0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld_req",   {31'd0, dmem_req},       32'd1);
        check("ld_we",    {31'd0, dmem_we},        32'd0);
        check("ld_addr",  dmem_addr,               32'h100);
        check("ld_stup",  {31'd0, stall_upstream}, 32'd0);
        check("ld_Stall", {31'd0, Stall},          32'd0);
        check("ld_wbv",   wb_value,                32'hDEAD_BEEF);
        check("ld_fwdv",  fwd_value,               32'hDEAD_BEEF);
        check("ld_fwd",   {31'd0, fwd_valid},      32'd1);
        check("ld_rd",    {27'd0, rd},             32'd5);

        // 3: store, three wait cycles; ex inputs change but must be ignored
        tick();
        for (int k = 0; k < 3; k++) begin
            dmem_ready = 1'b0;
            set_ex(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h77 + k, 32'h0, 32'h0, 5'd9);
            #1;
            check("st_stup",  {31'd0, stall_upstream}, 32'd1);
            check("st_Stall", {31'd0, Stall},          32'd1);
            check("st_we",    {31'd0, dmem_we},        32'd1);
            check("st_addr",  dmem_addr,               32'h200);
            check("st_wdata", dmem_wdata,              32'h1234);
            check("st_fwd",   {31'd0, fwd_valid},      32'd0);
            tick();
        end
        dmem_ready = 1'b1;
        set_ex(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_0999, 32'h0000_0044, 32'h0, 5'd1);
        #1;
        check("st_done_stup",  {31'd0, stall_upstream}, 32'd0);
        check("st_done_Stall", {31'd0, Stall},          32'd0);
        check("st_done_fwd",   {31'd0, fwd_valid},      32'd0);

        // 4: JAL
        tick();
        dmem_ready = 1'b0;
        dmem_rdata = 32'hFFFF_FFFF;
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0300, 32'h0, 32'h0, 5'd7);
        #1;
        check("jal_wbv",   wb_value,           32'h44);
        check("jal_Stall", {31'd0, Stall},     32'd0);
        check("jal_fwd",   {31'd0, fwd_valid}, 32'd1);
        check("jal_rd",    {27'd0, rd},        32'd1);
        check("jal_req",   {31'd0, dmem_req},  32'd0);

        // 5: load that never completes: 15 stalls, timeout retire on the 16th cycle
        tick();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        for (int k = 0; k < 15; k++) begin
            #1;
            check("to_stup",  {31'd0, stall_upstream}, 32'd1);
            check("to_Stall", {31'd0, Stall},          32'd1);
            check("to_berr",  {31'd0, bus_err},        32'd0);
            tick();
        end
        #1;
        check("to_last_stup",  {31'd0, stall_upstream}, 32'd0);
        check("to_last_Stall", {31'd0, Stall},          32'd0);
        check("to_last_wbv",   wb_value,                32'd0);
        check("to_last_fwd",   {31'd0, fwd_valid},      32'd1);
        check("to_last_addr",  dmem_addr,               32'h300);
        tick();
        check("to_berr_set",   {31'd0, bus_err},        32'd1);
        check("bubble_Stall",  {31'd0, Stall},          32'd1);
        check("bubble_req",    {31'd0, dmem_req},       32'd0);

        // 6: reset during the second wait cycle of a load
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0400, 32'h0, 32'h0, 5'd8);
        tick();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        check("berr_sticky",  {31'd0, bus_err},        32'd1);
        check("w1_stup",      {31'd0, stall_upstream}, 32'd1);
        tick();
        check("w2_req",       {31'd0, dmem_req},       32'd1);
        RSTN = 1'b0;
        #1;
        check("arst_req",   {31'd0, dmem_req},       32'd0);
        check("arst_Stall", {31'd0, Stall},          32'd1);
        check("arst_stup",  {31'd0, stall_upstream}, 32'd0);
        check("arst_berr",  {31'd0, bus_err},        32'd0);
        #1;
        RSTN = 1'b1;
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0500, 32'h0, 32'h0, 5'd9);
        tick();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        #1;
        check("post_req",  {31'd0, dmem_req},  32'd1);
        check("post_addr", dmem_addr,          32'h500);
        check("post_wbv",  wb_value,           32'hCAFE_F00D);
        check("post_fwd",  {31'd0, fwd_valid}, 32'd1);
        check("post_rd",   {27'd0, rd},        32'd9);
        check("post_berr", {31'd0, bus_err},   32'd0);
        tick();
        dmem_ready = 1'b0;
        #1;
        check("idle_req",   {31'd0, dmem_req}, 32'd0);
        check("idle_Stall", {31'd0, Stall},    32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
